// File: rtl/exec_datapath_core.sv
// exec_datapath_core: execute stage of the 18-bit single-cycle CPU.
// It holds the opcode decoder, the registered zero/carry flags, the ALU with
// its operand-B mux, and the 1024x18 data memory with the write-back mux.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   opcode            instruction[17:14]
//   op_a, op_b        register read data (op_b is also the store data)
//   imm               instruction[5:0], zero-extended
//   alu_result        ALU output, also the data-memory address
//   write_data        write-back value (memory read data or ALU result)
//   reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op, branch,
//   pc_write          combinational control strobes
//   zf, cf            registered zero/carry flags
//   nf                registered negative flag (EXEC_NEG_FLAG_EN only)
//
// Build option: defining EXEC_NEG_FLAG_EN adds the nf flag and turns
// opcode 1111 from NOP into BMI (branch if nf set).
module exec_datapath_core #(
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [5:0]        imm,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic [2:0]        alu_op,
    output logic              branch,
    output logic              pc_write,
    output logic              zf,
    output logic              cf
`ifdef EXEC_NEG_FLAG_EN
    ,
    output logic              nf
`endif
);

    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   sum_ext;
    logic              alu_carry;
    logic              alu_zero;
    logic              flag_upd;
    logic              taken;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Opcode decoder and branch resolution against the registered flags.
    always_comb begin
        alu_op     = 3'b101;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        taken      = 1'b0;
        pc_write   = 1'b0;
        case (opcode)
            4'b0000: begin alu_op = 3'b000; reg_write = 1'b1; end
            4'b0001: begin alu_op = 3'b001; reg_write = 1'b1; end
            4'b0010: begin alu_op = 3'b010; alu_src = 1'b1; reg_write = 1'b1; end
            4'b0011: begin alu_op = 3'b010; reg_write = 1'b1; end
            4'b0100: begin alu_op = 3'b011; reg_write = 1'b1; end
            4'b0101: begin alu_op = 3'b100; reg_write = 1'b1; end
            4'b0110: begin alu_op = 3'b000; alu_src = 1'b1; reg_write = 1'b1; end
            4'b0111: begin alu_op = 3'b001; alu_src = 1'b1; reg_write = 1'b1; end
            4'b1000: begin
                alu_op     = 3'b010;
                alu_src    = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
            end
            4'b1001: begin alu_op = 3'b010; alu_src = 1'b1; mem_write = 1'b1; end
            4'b1010: pc_write = 1'b1;
            4'b1011: alu_op = 3'b100;
            4'b1100: begin branch = 1'b1; taken = zf; end
            4'b1101: begin branch = 1'b1; taken = ~zf; end
            4'b1110: begin branch = 1'b1; taken = cf; end
`ifdef EXEC_NEG_FLAG_EN
            4'b1111: begin branch = 1'b1; taken = nf; end
`endif
            default: ;
        endcase
        if (branch && taken) begin
            pc_write = 1'b1;
        end
    end

    assign alu_b   = alu_src ? DATA_W'(imm) : op_b;
    assign sum_ext = {1'b0, op_a} + {1'b0, alu_b};

    // ALU; carry is the add carry-out or the subtract borrow, else zero.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (alu_op)
            3'b000: alu_result = op_a & alu_b;
            3'b001: alu_result = op_a | alu_b;
            3'b010: begin
                alu_result = sum_ext[DATA_W-1:0];
                alu_carry  = sum_ext[DATA_W];
            end
            3'b011: alu_result = op_a ^ alu_b;
            3'b100: begin
                alu_result = op_a - alu_b;
                alu_carry  = (op_a < alu_b);
            end
            3'b101: alu_result = alu_b;
            3'b110: alu_result = ~(op_a | alu_b);
            default: alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == '0);

    // Flags are written by the ALU-class opcodes (0xxx) and CMP only.
    assign flag_upd = ~opcode[3] | (opcode == 4'b1011);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zf <= 1'b0;
            cf <= 1'b0;
        end else if (flag_upd) begin
            zf <= alu_zero;
            cf <= alu_carry;
        end
    end

`ifdef EXEC_NEG_FLAG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nf <= 1'b0;
        end else if (flag_upd) begin
            nf <= alu_result[DATA_W-1];
        end
    end
`endif

    // Data memory: upper address bits are dropped so addresses wrap.
    assign mem_addr = alu_result[ADDR_W-1:0];

    // Stores are suppressed while reset is asserted; contents are never cleared.
    always_ff @(posedge clk) begin
        if (mem_write && reset) begin
            mem[mem_addr] <= op_b;
        end
    end

    assign mem_rdata  = mem_read ? mem[mem_addr] : '0;
    assign write_data = mem_to_reg ? mem_rdata : alu_result;

endmodule

// File: tb/tb_exec_datapath_core.sv
// tb_exec_datapath_core: randomized and directed bench for exec_datapath_core
// against an arithmetic reference model of the instruction set.
module tb_exec_datapath_core;

    logic        clk;
    logic        reset;
    logic [3:0]  opcode;
    logic [17:0] op_a;
    logic [17:0] op_b;
    logic [5:0]  imm;
    logic [17:0] alu_result;
    logic [17:0] write_data;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic [2:0]  alu_op;
    logic        branch, pc_write, zf, cf;
`ifdef EXEC_NEG_FLAG_EN
    logic        nf;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state: flags and the words the bench has stored.
    logic        mdl_zf, mdl_cf, mdl_nf;
    logic [17:0] mdl_mem [1024];
    bit          mdl_vld [1024];

    exec_datapath_core dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .op_a       (op_a),
        .op_b       (op_b),
        .imm        (imm),
        .alu_result (alu_result),
        .write_data (write_data),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .branch     (branch),
        .pc_write   (pc_write),
        .zf         (zf),
        .cf         (cf)
`ifdef EXEC_NEG_FLAG_EN
        ,
        .nf         (nf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one instruction after a falling edge, check all outputs,
    // then advance the model across the next rising edge.
    task automatic do_cycle(input logic rst, input logic [3:0] op, input logic [17:0] a,
                            input logic [17:0] b, input logic [5:0] im);
        logic [17:0] bv, res;
        logic [2:0]  aop;
        logic        cy, src, rw, mr, mw, br, tk, pcw, upd;
        longint      sum;
        int          addr;
        @(negedge clk);
        reset  = rst;
        opcode = op;
        op_a   = a;
        op_b   = b;
        imm    = im;
        if (!rst) begin
            mdl_zf = 1'b0;
            mdl_cf = 1'b0;
            mdl_nf = 1'b0;
        end
        #1;
        src = op inside {4'd2, 4'd6, 4'd7, 4'd8, 4'd9};
        bv  = src ? 18'(im) : b;
        cy  = 1'b0;
        case (op)
            4'd0, 4'd6: begin res = a & bv; aop = 3'd0; end
            4'd1, 4'd7: begin res = a | bv; aop = 3'd1; end
            4'd2, 4'd3, 4'd8, 4'd9: begin
                sum = longint'(a) + longint'(bv);
                res = 18'(sum);
                cy  = (sum >= longint'(2**18));
                aop = 3'd2;
            end
            4'd4: begin res = a ^ bv; aop = 3'd3; end
            4'd5, 4'd11: begin
                res = 18'(a - bv);
                cy  = (a < bv);
                aop = 3'd4;
            end
            default: begin res = bv; aop = 3'd5; end
        endcase
        rw  = (op <= 4'd8);
        mr  = (op == 4'd8);
        mw  = (op == 4'd9);
        upd = (op <= 4'd7) || (op == 4'd11);
        br  = op inside {4'd12, 4'd13, 4'd14};
        tk  = (op == 4'd12) ? mdl_zf : (op == 4'd13) ? !mdl_zf : (op == 4'd14) ? mdl_cf : 1'b0;
`ifdef EXEC_NEG_FLAG_EN
        if (op == 4'd15) begin
            br = 1'b1;
            tk = mdl_nf;
        end
`endif
        pcw  = (op == 4'd10) || (br && tk);
        addr = int'(res[9:0]);
        check($sformatf("alu_result op%0d", op), 32'(alu_result), 32'(res));
        check($sformatf("alu_op op%0d", op), 32'(alu_op), 32'(aop));
        check($sformatf("strobes op%0d", op),
              32'({alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch}),
              32'({src, rw, mr, mw, mr, br}));
        check($sformatf("pc_write op%0d", op), 32'(pc_write), 32'(pcw));
        check($sformatf("flags op%0d", op), 32'({zf, cf}), 32'({mdl_zf, mdl_cf}));
`ifdef EXEC_NEG_FLAG_EN
        check($sformatf("nf op%0d", op), 32'(nf), 32'(mdl_nf));
`endif
        if (!mr) begin
            check($sformatf("write_data op%0d", op), 32'(write_data), 32'(res));
        end else if (mdl_vld[addr]) begin
            check($sformatf("load addr%0h", addr), 32'(write_data), 32'(mdl_mem[addr]));
        end
        @(posedge clk);
        if (rst) begin
            if (upd) begin
                mdl_zf = (res == 18'd0);
                mdl_cf = cy;
                mdl_nf = res[17];
            end
            if (mw) begin
                mdl_mem[addr] = b;
                mdl_vld[addr] = 1'b1;
            end
        end
    endtask

    initial begin
        logic [17:0] ra, rb;
        reset  = 1'b0;
        opcode = 4'd15;
        op_a   = '0;
        op_b   = '0;
        imm    = '0;
        mdl_zf = 1'b0;
        mdl_cf = 1'b0;
        mdl_nf = 1'b0;

        do_cycle(1'b0, 4'd15, 18'd0, 18'd0, 6'd0);
        do_cycle(1'b0, 4'd9, 18'd5, 18'h1, 6'd0);
        // ADDI, ADD overflow and the flags they leave behind
        do_cycle(1'b1, 4'd2, 18'h00005, 18'h0, 6'h3F);
        do_cycle(1'b1, 4'd3, 18'h3FFFF, 18'h00001, 6'd0);
        do_cycle(1'b1, 4'd15, 18'd0, 18'd0, 6'd0);
        // store/load with address wrap at 0x400
        do_cycle(1'b1, 4'd9, 18'h003F0, 18'h2ABCD, 6'h10);
        do_cycle(1'b1, 4'd8, 18'h0, 18'h0, 6'h0);
        do_cycle(1'b1, 4'd9, 18'h00400, 18'h15555, 6'h0);
        do_cycle(1'b1, 4'd8, 18'h0, 18'h0, 6'h0);
        // async flag clear and suppressed store while in reset
        do_cycle(1'b1, 4'd3, 18'h3FFFF, 18'h00001, 6'd0);
        do_cycle(1'b0, 4'd9, 18'h0, 18'h3FFFF, 6'h0);
        do_cycle(1'b1, 4'd8, 18'h0, 18'h0, 6'h0);
        // branches resolved on the registered flags
        do_cycle(1'b1, 4'd11, 18'd7, 18'd7, 6'd0);
        do_cycle(1'b1, 4'd12, 18'd0, 18'd0, 6'd0);
        do_cycle(1'b1, 4'd13, 18'd0, 18'd0, 6'd0);
        do_cycle(1'b1, 4'd11, 18'd3, 18'd9, 6'd0);
        do_cycle(1'b1, 4'd14, 18'd0, 18'd0, 6'd0);
        do_cycle(1'b1, 4'd10, 18'd0, 18'd0, 6'd0);
        // full opcode sweep
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b1, 4'(i), 18'($urandom), 18'($urandom), 6'($urandom));
        end
        // random instruction stream, small operands biased to hit memory and flags
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 1) == 1) ? 18'($urandom) : 18'($urandom_range(0, 40));
            rb = ($urandom_range(0, 1) == 1) ? 18'($urandom) : 18'($urandom_range(0, 40));
            do_cycle(1'b1, 4'($urandom_range(0, 15)), ra, rb, 6'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
